// File: rtl/mem_data_hs.sv
// Data memory with valid/ready request and response channels, programmable wait
// states, per-lane write enables and an out-of-range error response.
module mem_data_hs #(
    parameter int unsigned p_WORD_LEN  = 16,
    parameter int unsigned p_LANE_LEN  = 8,
    parameter int unsigned p_ADDR_LEN  = 16,
    parameter int unsigned p_MEM_DEPTH = 1024,
    parameter int unsigned p_WAIT      = 0
) (
    input  logic                                i_clk,
    input  logic                                i_rst_n,
    input  logic                                i_req_valid,
    output logic                                o_req_ready,
    input  logic                                i_req_we,
    input  logic [p_ADDR_LEN-1:0]               i_req_addr,
    input  logic [p_WORD_LEN-1:0]               i_req_wdata,
    input  logic [p_WORD_LEN/p_LANE_LEN-1:0]    i_req_be,
    output logic                                o_rsp_valid,
    input  logic                                i_rsp_ready,
    output logic [p_WORD_LEN-1:0]               o_rsp_data,
    output logic                                o_rsp_err
);

    localparam int unsigned p_LANES = p_WORD_LEN / p_LANE_LEN;
    localparam int unsigned IDX_W   = (p_MEM_DEPTH > 1) ? $clog2(p_MEM_DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    we_q, we_d;
    logic [p_ADDR_LEN-1:0]   addr_q, addr_d;
    logic [p_WORD_LEN-1:0]   wdata_q, wdata_d;
    logic [p_LANES-1:0]      be_q, be_d;
    logic [p_WORD_LEN-1:0]   rsp_data_q, rsp_data_d;
    logic                    rsp_err_q, rsp_err_d;

    logic                    mem_wr;
    logic                    in_range;
    logic [IDX_W-1:0]        idx;
    logic [p_WORD_LEN-1:0]   mem_rdata;

    // Storage is zero at start of simulation and deliberately untouched by reset.
    logic [p_WORD_LEN-1:0]   mem [p_MEM_DEPTH] = '{default: '0};

    assign in_range  = {1'b0, addr_q} < (p_ADDR_LEN+1)'(p_MEM_DEPTH);
    assign idx       = addr_q[IDX_W-1:0];
    assign mem_rdata = mem[idx];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        mem_wr     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (i_req_valid) begin
                    we_d    = i_req_we;
                    addr_d  = i_req_addr;
                    wdata_d = i_req_wdata;
                    be_d    = i_req_be;
                    cnt_d   = 4'(p_WAIT);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = S_RESP;
                    if (in_range) begin
                        mem_wr     = we_q;
                        rsp_data_d = we_q ? '0 : mem_rdata;
                        rsp_err_d  = 1'b0;
                    end else begin
                        rsp_data_d = '0;
                        rsp_err_d  = 1'b1;
                    end
                end
            end
            S_RESP: begin
                if (i_rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (mem_wr) begin
            for (int unsigned k = 0; k < p_LANES; k++) begin
                if (be_q[k]) begin
                    mem[idx][k*p_LANE_LEN +: p_LANE_LEN] <= wdata_q[k*p_LANE_LEN +: p_LANE_LEN];
                end
            end
        end
    end

    assign o_req_ready = (state_q == S_IDLE);
    assign o_rsp_valid = (state_q == S_RESP);
    assign o_rsp_data  = rsp_data_q;
    assign o_rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_data_hs.sv
// Self-checking bench for mem_data_hs: three instances with 0, 3 and 5 wait states,
// directed vector table, reset-in-WAIT sequence and randomized traffic vs. a model.
module tb_mem_data_hs;

    localparam int NI    = 3;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid [NI];
    logic        req_ready [NI];
    logic        req_we    [NI];
    logic [15:0] req_addr  [NI];
    logic [15:0] req_wdata [NI];
    logic [1:0]  req_be    [NI];
    logic        rsp_valid [NI];
    logic        rsp_ready [NI];
    logic [15:0] rsp_data  [NI];
    logic        rsp_err   [NI];

    int n_pass  = 0;
    int n_total = 0;

    logic [15:0] mdl [NI][DEPTH];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        mem_data_hs #(
            .p_WORD_LEN (16),
            .p_LANE_LEN (8),
            .p_ADDR_LEN (16),
            .p_MEM_DEPTH(DEPTH),
            .p_WAIT     ((g == 0) ? 0 : (g == 1) ? 3 : 5)
        ) u_dut (
            .i_clk      (clk),
            .i_rst_n    (rst_n),
            .i_req_valid(req_valid[g]),
            .o_req_ready(req_ready[g]),
            .i_req_we   (req_we[g]),
            .i_req_addr (req_addr[g]),
            .i_req_wdata(req_wdata[g]),
            .i_req_be   (req_be[g]),
            .o_rsp_valid(rsp_valid[g]),
            .i_rsp_ready(rsp_ready[g]),
            .o_rsp_data (rsp_data[g]),
            .o_rsp_err  (rsp_err[g])
        );
    end

    function automatic int wait_of(input int d);
        return (d == 0) ? 0 : (d == 1) ? 3 : 5;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    endtask

    // Reference behaviour: byte-masked merge on write, plain lookup on read,
    // anything at or above the depth is an error with no storage effect.
    task automatic model_access(input int d, input bit we, input logic [15:0] addr,
                                input logic [15:0] wdata, input logic [1:0] be,
                                output logic [15:0] data, output bit err);
        int a;
        a = int'(addr);
        if (a >= DEPTH) begin
            data = 16'h0;
            err  = 1'b1;
        end else begin
            err = 1'b0;
            if (we) begin
                if (be[0]) mdl[d][a] = (mdl[d][a] & 16'hFF00) | (wdata & 16'h00FF);
                if (be[1]) mdl[d][a] = (mdl[d][a] & 16'h00FF) | (wdata & 16'hFF00);
                data = 16'h0;
            end else begin
                data = mdl[d][a];
            end
        end
    endtask

    // One full transaction. hold > 0 keeps rsp_ready low for that many cycles of RESP.
    task automatic do_access(input int d, input bit we, input logic [15:0] addr,
                             input logic [15:0] wdata, input logic [1:0] be, input int hold,
                             input logic [15:0] exp_data, input bit exp_err);
        int          lat;
        bit          busy_ok;
        bit          stable_ok;
        logic [15:0] d0;
        logic        e0;

        @(negedge clk);
        chk("req_ready_idle", 32'(req_ready[d]), 32'd1);
        rsp_ready[d] = (hold == 0);
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_be[d]    = be;
        @(posedge clk);
        @(negedge clk);
        // Ghost write to a low address: would corrupt later reads if ever accepted.
        req_we[d]    = 1'b1;
        req_addr[d]  = 16'($urandom_range(0, 15));
        req_wdata[d] = 16'($urandom);
        req_be[d]    = 2'b11;
        lat     = 0;
        busy_ok = 1'b1;
        while (!rsp_valid[d] && lat < 40) begin
            if (req_ready[d]) busy_ok = 1'b0;
            @(negedge clk);
            req_valid[d] = 1'b0;
            lat++;
        end
        req_valid[d] = 1'b0;
        chk("busy_ready_low", 32'(busy_ok), 32'd1);
        chk("latency", 32'(lat), 32'(wait_of(d) + 1));
        chk("rsp_data", 32'(rsp_data[d]), 32'(exp_data));
        chk("rsp_err", 32'(rsp_err[d]), 32'(exp_err));
        chk("ready_in_resp", 32'(req_ready[d]), 32'd0);
        if (hold > 0) begin
            d0 = rsp_data[d];
            e0 = rsp_err[d];
            stable_ok = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                req_valid[d] = (i == 1);
                if (!rsp_valid[d] || rsp_data[d] !== d0 || rsp_err[d] !== e0 || req_ready[d])
                    stable_ok = 1'b0;
            end
            req_valid[d] = 1'b0;
            chk("bp_stable", 32'(stable_ok), 32'd1);
            rsp_ready[d] = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        chk("post_hs", {30'd0, rsp_valid[d], req_ready[d]}, 32'b01);
    endtask

    typedef struct {
        int          d;
        bit          we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be;
        int          hold;
        logic [15:0] exp_data;
        bit          exp_err;
    } vec_t;

    vec_t vt [15];

    initial begin
        logic [15:0] md;
        bit          me;
        int          r;
        int          d;
        logic [15:0] a;

        vt[0]  = '{0, 1'b0, 16'd5,    16'h0000, 2'b00, 0, 16'h0000, 1'b0};
        vt[1]  = '{1, 1'b1, 16'd10,   16'hBEEF, 2'b11, 0, 16'h0000, 1'b0};
        vt[2]  = '{1, 1'b0, 16'd10,   16'h0000, 2'b00, 0, 16'hBEEF, 1'b0};
        vt[3]  = '{1, 1'b1, 16'd7,    16'h1234, 2'b11, 0, 16'h0000, 1'b0};
        vt[4]  = '{1, 1'b1, 16'd7,    16'hAB00, 2'b10, 0, 16'h0000, 1'b0};
        vt[5]  = '{1, 1'b0, 16'd7,    16'h0000, 2'b00, 0, 16'hAB34, 1'b0};
        vt[6]  = '{1, 1'b1, 16'd7,    16'hFFFF, 2'b00, 0, 16'h0000, 1'b0};
        vt[7]  = '{1, 1'b0, 16'd7,    16'h0000, 2'b00, 5, 16'hAB34, 1'b0};
        vt[8]  = '{0, 1'b1, 16'd1024, 16'h5555, 2'b11, 0, 16'h0000, 1'b1};
        vt[9]  = '{0, 1'b0, 16'd0,    16'h0000, 2'b00, 0, 16'h0000, 1'b0};
        vt[10] = '{0, 1'b0, 16'd1023, 16'h0000, 2'b00, 0, 16'h0000, 1'b0};
        vt[11] = '{0, 1'b0, 16'hFFFF, 16'h0000, 2'b00, 2, 16'h0000, 1'b1};
        vt[12] = '{0, 1'b1, 16'd1023, 16'hC3A5, 2'b01, 0, 16'h0000, 1'b0};
        vt[13] = '{0, 1'b0, 16'd1023, 16'h0000, 2'b00, 0, 16'h00A5, 1'b0};
        vt[14] = '{2, 1'b1, 16'd3,    16'h1357, 2'b11, 0, 16'h0000, 1'b0};

        for (int i = 0; i < NI; i++) begin
            for (int j = 0; j < DEPTH; j++) mdl[i][j] = 16'h0;
            req_valid[i] = 1'b0;
            req_we[i]    = 1'b0;
            req_addr[i]  = 16'h0;
            req_wdata[i] = 16'h0;
            req_be[i]    = 2'b00;
            rsp_ready[i] = 1'b1;
        end

        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk("rst_req_ready", 32'(req_ready[i]), 32'd1);
            chk("rst_rsp_valid", 32'(rsp_valid[i]), 32'd0);
            chk("rst_rsp_data", 32'(rsp_data[i]), 32'd0);
            chk("rst_rsp_err", 32'(rsp_err[i]), 32'd0);
        end
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            model_access(vt[i].d, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].be, md, me);
            do_access(vt[i].d, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].be, vt[i].hold,
                      vt[i].exp_data, vt[i].exp_err);
        end

        // Reset two cycles into a 5-wait-state write: the write must be dropped.
        @(negedge clk);
        chk("rw_idle", 32'(req_ready[2]), 32'd1);
        req_valid[2] = 1'b1;
        req_we[2]    = 1'b1;
        req_addr[2]  = 16'd3;
        req_wdata[2] = 16'h7777;
        req_be[2]    = 2'b11;
        @(posedge clk);
        @(negedge clk);
        req_valid[2] = 1'b0;
        @(negedge clk);
        chk("rw_busy", 32'(req_ready[2]), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rw_rst_ready", 32'(req_ready[2]), 32'd1);
        chk("rw_rst_valid", 32'(rsp_valid[2]), 32'd0);
        chk("rw_rst_data", 32'(rsp_data[2]), 32'd0);
        chk("rw_rst_err", 32'(rsp_err[2]), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        do_access(2, 1'b0, 16'd3, 16'h0, 2'b00, 0, 16'h1357, 1'b0);

        for (int n = 0; n < 150; n++) begin
            d = int'($urandom_range(0, NI - 1));
            r = int'($urandom_range(0, 9));
            if (r < 8)       a = 16'($urandom_range(0, 15));
            else if (r == 8) a = 16'($urandom_range(1020, 1027));
            else             a = 16'($urandom_range(1024, 65535));
            begin
                bit          we;
                logic [15:0] wd;
                logic [1:0]  be;
                int          hold;
                we   = 1'($urandom);
                wd   = 16'($urandom);
                be   = 2'($urandom);
                hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
                model_access(d, we, a, wd, be, md, me);
                do_access(d, we, a, wd, be, hold, md, me);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
